// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 (modified Booth) multiplier with start/done handshake.
// Retires two multiplier bits per cycle; signed/unsigned selected per operation.
module booth4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int EW = WIDTH + 2;
  localparam int AW = EW + 2;
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth4_seq_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [AW-1:0]        r_acc;
  logic [EW-1:0]        r_x;
  logic [EW-1:0]        r_y;
  logic                 r_xm1;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic [EW-1:0]        w_x_ext;
  logic [EW-1:0]        w_y_ext;
  logic                 w_zero;
  logic [AW-1:0]        w_y1;
  logic [AW-1:0]        w_y2;
  logic [AW-1:0]        w_addend;
  logic [AW-1:0]        w_sum;
  logic [AW-1:0]        w_acc_next;
  logic [EW-1:0]        w_x_next;

  // Two extra bits keep unsigned operands positive under the signed Booth recoding.
  assign w_x_ext = tc ? {{2{multiplier[WIDTH-1]}}, multiplier}     : {2'b00, multiplier};
  assign w_y_ext = tc ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign w_zero  = (multiplier == '0) || (multiplicand == '0);

  assign w_y1 = {{2{r_y[EW-1]}}, r_y};
  assign w_y2 = {r_y[EW-1], r_y, 1'b0};

  always_comb begin
    w_addend = '0;
    case ({r_x[1:0], r_xm1})
      3'b001, 3'b010: w_addend = w_y1;
      3'b011:         w_addend = w_y2;
      3'b100:         w_addend = -w_y2;
      3'b101, 3'b110: w_addend = -w_y1;
      default:        w_addend = '0;
    endcase
  end

  assign w_sum      = r_acc + w_addend;
  assign w_acc_next = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_x_next   = {w_sum[1:0], r_x[EW-1:2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_xm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_zero) begin
              r_product <= '0;
              r_state   <= DONE;
            end else begin
              r_acc   <= '0;
              r_x     <= w_x_ext;
              r_y     <= w_y_ext;
              r_xm1   <= 1'b0;
              r_cnt   <= N_CNT;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_x   <= w_x_next;
          r_xm1 <= r_x[1];
          r_cnt <= r_cnt - 1'b1;
          // Last iteration: the shifted pair now holds the complete product.
          if (r_cnt == CW'(1)) begin
            r_product <= {w_acc_next[WIDTH-3:0], w_x_next};
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Bench for booth4_seq_mult: WIDTH=8 and WIDTH=16 instances checked each cycle
// against an arithmetic timeline model, plus directed literal operations.
module tb_booth4_seq_mult;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        s8 = 1'b0, t8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        rd8, bz8, dn8;
  logic [15:0] p8;

  logic        s16 = 1'b0, t16 = 1'b0;
  logic [15:0] x16 = '0, y16 = '0;
  logic        rd16, bz16, dn16;
  logic [31:0] p16;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;

  always #5 clk = ~clk;

  booth4_seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .tc(t8),
    .multiplier(x8), .multiplicand(y8),
    .ready(rd8), .busy(bz8), .done(dn8), .product(p8)
  );

  booth4_seq_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(s16), .tc(t16),
    .multiplier(x16), .multiplicand(y16),
    .ready(rd16), .busy(bz16), .done(dn16), .product(p16)
  );

  // Model inputs, index 0 = WIDTH 8, index 1 = WIDTH 16
  logic        in_s [2];
  logic        in_t [2];
  logic [15:0] in_x [2];
  logic [15:0] in_y [2];
  assign in_s[0] = s8;   assign in_t[0] = t8;
  assign in_x[0] = {8'h00, x8};  assign in_y[0] = {8'h00, y8};
  assign in_s[1] = s16;  assign in_t[1] = t16;
  assign in_x[1] = x16;  assign in_y[1] = y16;

  // Exact mathematical product truncated to 2*w bits
  function automatic bit [31:0] ref_mul(int w, logic t, logic [15:0] x, logic [15:0] y);
    longint a, b, p;
    a = longint'(x) & ((longint'(1) << w) - 1);
    b = longint'(y) & ((longint'(1) << w) - 1);
    if (t && a[w-1]) a = a - (longint'(1) << w);
    if (t && b[w-1]) b = b - (longint'(1) << w);
    p = a * b;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  // Timeline model: cycles of RUN left, DONE flag, held product
  int        m_left [2];
  bit        m_done [2];
  bit [31:0] m_prod [2];
  bit [31:0] m_pend [2];
  int        n_acc  [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] <= 0;
        m_done[k] <= 1'b0;
        m_prod[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_done[k]) begin
          m_done[k] <= 1'b0;
        end else if (m_left[k] > 0) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_prod[k] <= m_pend[k];
            m_done[k] <= 1'b1;
          end
        end else if (in_s[k]) begin
          n_acc[k] <= n_acc[k] + 1;
          if (in_x[k] == 16'h0 || in_y[k] == 16'h0) begin
            m_prod[k] <= '0;
            m_done[k] <= 1'b1;
          end else begin
            m_left[k] <= (k == 0) ? 5 : 9;
            m_pend[k] <= ref_mul((k == 0) ? 8 : 16, in_t[k], in_x[k], in_y[k]);
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  initial begin
    logic        a_r, a_b, a_d;
    logic [31:0] a_p;
    bit          e_r, e_b;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin a_r = rd8;  a_b = bz8;  a_d = dn8;  a_p = {16'h0, p8}; end
        else        begin a_r = rd16; a_b = bz16; a_d = dn16; a_p = p16;         end
        e_r = !m_done[k] && (m_left[k] == 0);
        e_b = (m_left[k] > 0);
        n_tests++;
        if (a_r !== e_r || a_b !== e_b || a_d !== m_done[k] || a_p !== m_prod[k]) begin
          n_fail++;
          if (n_print < 30) begin
            n_print++;
            $display("FAIL cycle w%0d @%0t: ready/busy/done/product=%b%b%b %h, required %b%b%b %h",
                     (k == 0) ? 8 : 16, $time, a_r, a_b, a_d, a_p, e_r, e_b, m_done[k], m_prod[k]);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(int k, logic s, logic t, logic [15:0] x, logic [15:0] y);
    if (k == 0) begin s8 = s;  t8 = t;  x8 = x[7:0]; y8 = y[7:0]; end
    else        begin s16 = s; t16 = t; x16 = x;     y16 = y;     end
  endtask

  function automatic logic [31:0] get_prod(int k);
    return (k == 0) ? {16'h0, p8} : p16;
  endfunction

  function automatic logic get_done(int k);
    return (k == 0) ? dn8 : dn16;
  endfunction

  function automatic logic get_busy(int k);
    return (k == 0) ? bz8 : bz16;
  endfunction

  function automatic logic [15:0] rnd_op(int w);
    int r;
    logic [15:0] m;
    r = $urandom_range(0, 15);
    m = (w == 8) ? 16'h00FF : 16'hFFFF;
    case (r)
      0:       return 16'h0;
      1:       return 16'h1 << (w - 1);
      2:       return m;
      3:       return m >> 1;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  // One operation from the IDLE state; hold=1 keeps start high and scrambles operands during RUN.
  task automatic do_op(int k, logic t, logic [15:0] x, logic [15:0] y,
                       logic [31:0] exp_p, int exp_lat, bit hold, string name);
    int          lat;
    bit          got, busy_seen, held_ok;
    logic [31:0] prev;
    @(negedge clk); #1;
    prev = get_prod(k);
    drive(k, 1'b1, t, x, y);
    got = 0; lat = 0; busy_seen = 0; held_ok = 1;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      drive(k, hold, 1'($urandom), 16'($urandom), 16'($urandom));
      if (get_done(k)) got = 1;
      else begin
        if (get_busy(k)) busy_seen = 1;
        if (get_prod(k) !== prev) held_ok = 0;
      end
    end
    drive(k, 1'b0, 1'b0, 16'h0, 16'h0);
    chk({name, " done seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " product"}, get_prod(k), exp_p);
    chk({name, " product held"}, 32'(held_ok), 32'd1);
    chk({name, " busy seen"}, 32'(busy_seen), 32'(exp_lat > 1));
    $display("[TB] %s: w=%0d tc=%0d x=%h y=%h -> product=%h latency=%0d",
             name, (k == 0) ? 8 : 16, t, x, y, get_prod(k), lat);
    @(posedge clk);
  endtask

  initial begin
    int base0, base1, cyc, dn_seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready8", 32'(rd8), 32'd1);
    chk("reset busy8", 32'(bz8), 32'd0);
    chk("reset done8", 32'(dn8), 32'd0);
    chk("reset product8", {16'h0, p8}, 32'h0);
    chk("reset ready16", 32'(rd16), 32'd1);
    chk("reset product16", p16, 32'h0);
    reset = 1'b1;

    chk("model s8 min*min", ref_mul(8, 1'b1, 16'h80, 16'h80), 32'h4000);
    chk("model s8 -1*127", ref_mul(8, 1'b1, 16'hFF, 16'h7F), 32'hFF81);
    chk("model u16 ffff*2", ref_mul(16, 1'b0, 16'hFFFF, 16'h0002), 32'h0001FFFE);

    do_op(0, 1'b1, 16'h80, 16'h80, 32'h4000, 6, 1'b0, "s8 min*min");
    do_op(0, 1'b0, 16'hFF, 16'hFF, 32'hFE01, 6, 1'b0, "u8 ff*ff");
    do_op(0, 1'b1, 16'hFF, 16'hFF, 32'h0001, 6, 1'b0, "s8 ff*ff");
    do_op(0, 1'b1, 16'hFF, 16'h7F, 32'hFF81, 6, 1'b0, "s8 -1*127");
    do_op(0, 1'b1, 16'h05, 16'hFD, 32'hFFF1, 6, 1'b0, "s8 5*-3 back-to-back");
    do_op(0, 1'b1, 16'h00, 16'h5A, 32'h0000, 1, 1'b0, "early-out x=0");
    do_op(0, 1'b1, 16'hF9, 16'h03, 32'hFFEB, 6, 1'b1, "s8 -7*3 start held");
    do_op(0, 1'b0, 16'h37, 16'h00, 32'h0000, 1, 1'b0, "early-out y=0");
    do_op(0, 1'b0, 16'hC8, 16'h03, 32'h0258, 6, 1'b0, "u8 200*3");

    // Abort mid-RUN with a reset pulse
    @(negedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'h03, 16'h07);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort ready", 32'(rd8), 32'd1);
    chk("abort busy", 32'(bz8), 32'd0);
    chk("abort product", {16'h0, p8}, 32'h0);
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    dn_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (dn8) dn_seen++;
    end
    chk("abort no done", 32'(dn_seen), 32'd0);
    do_op(0, 1'b0, 16'h03, 16'h07, 32'h0015, 6, 1'b0, "u8 3*7 after abort");

    do_op(1, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 10, 1'b0, "s16 min*min");
    do_op(1, 1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE, 10, 1'b0, "u16 ffff*2");
    do_op(1, 1'b1, 16'hFFFD, 16'h1234, 32'hFFFFC964, 10, 1'b0, "s16 -3*0x1234");

    // Randomized sweep on both widths in parallel
    base0 = n_acc[0];
    base1 = n_acc[1];
    cyc = 0;
    while (((n_acc[0] - base0) < 5000 || (n_acc[1] - base1) < 5000) && cyc < 70000) begin
      @(negedge clk); #1;
      cyc++;
      drive(0, ((n_acc[0] - base0) < 5000) && ($urandom_range(0, 3) != 0),
            1'($urandom), rnd_op(8), rnd_op(8));
      drive(1, ((n_acc[1] - base1) < 5000) && ($urandom_range(0, 3) != 0),
            1'($urandom), rnd_op(16), rnd_op(16));
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("sweep8 completed", 32'((n_acc[0] - base0) >= 5000), 32'd1);
    chk("sweep16 completed", 32'((n_acc[1] - base1) >= 5000), 32'd1);
    $display("[TB] sweep: %0d w8 and %0d w16 operations in %0d cycles",
             n_acc[0] - base0, n_acc[1] - base1, cyc);
    repeat (15) @(posedge clk);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
